jt03_snd_mix: RTL and testbench

- Downstream consumer of the YM2203-mode core output.
- Captures the FM and combined PSG sample on each sample strobe, centres the PSG, and applies independent per-source gain.
- Sums and saturates to a signed 16-bit stream with a valid strobe and a sticky clip flag.
- Feeds the board-level audio DAC/resampler.

---
 rtl/jt03_snd_mix.sv | 145 ++++++++++++++
 tb/tb_jt03_snd_mix.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/jt03_snd_mix.sv
// FM + PSG sound mixer: centre the PSG, apply per-source Q4.4 gain, sum and saturate to s16.
// Latency: 3 cycles from snd_sample to snd_valid, fully pipelined (one sample per cycle).
// Backpressure: none; every snd_valid must be consumed. Optional PSG DC blocker: JT03_DCRM_EN.
module jt03_snd_mix #(
  parameter int PSG_SHIFT = 5,
  parameter int DC_SHIFT  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] fm_snd,
  input  logic        [9:0]  psg_snd,
  input  logic               snd_sample,
  input  logic        [7:0]  fm_gain,
  input  logic        [7:0]  psg_gain,
  input  logic               clip_clr,
  output logic signed [15:0] snd,
  output logic               snd_valid,
  output logic               clip
);

  localparam int PSW = 11 + PSG_SHIFT;            // centred PSG after alignment shift
  localparam int PMW = PSW + 9;                   // PSG product width
  localparam int PPW = PMW - 4;                   // PSG term after gain scaling
  localparam int SW  = ((PPW > 21) ? PPW : 21) + 1;
  localparam logic signed [SW-1:0] SAT_HI = SW'(32767);
  localparam logic signed [SW-1:0] SAT_LO = SW'(-32768);

  if (DC_SHIFT < 1 || DC_SHIFT > 12) begin : g_bad_dc_shift
    $error("jt03_snd_mix: DC_SHIFT must be in 1..12");
  end
  if (PSG_SHIFT < 0 || PSG_SHIFT > 8) begin : g_bad_psg_shift
    $error("jt03_snd_mix: PSG_SHIFT must be in 0..8");
  end

  // ---------------- S0: capture FM, produce centred PSG ----------------
  logic signed [15:0] fm_r;
  logic signed [10:0] psg_c, psg_c_nxt;
  logic               s0_vld;

`ifdef JT03_DCRM_EN
  // DC blocker state keeps DC_SHIFT fractional bits so the slow pole decay is not lost.
  localparam int YW = 14 + DC_SHIFT;
  localparam logic signed [YW-1:0] DC_HI = YW'(511);
  localparam logic signed [YW-1:0] DC_LO = YW'(-512);
  logic        [9:0]    dc_x;
  logic signed [11:0]   dc_dx;
  logic signed [YW-1:0] dc_y, dc_y_nxt, dc_int;

  // Next filter output and its clamped integer part.
  always_comb begin
    dc_dx    = $signed({2'b00, psg_snd}) - $signed({2'b00, dc_x});
    dc_y_nxt = ($signed({{(YW-12){dc_dx[11]}}, dc_dx}) <<< DC_SHIFT) + dc_y - (dc_y >>> DC_SHIFT);
    dc_int   = dc_y_nxt >>> DC_SHIFT;
    if (dc_int > DC_HI)      psg_c_nxt = 11'sd511;
    else if (dc_int < DC_LO) psg_c_nxt = -11'sd512;
    else                     psg_c_nxt = dc_int[10:0];
  end

  // Filter history advances only on accepted samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      dc_x <= '0;
      dc_y <= '0;
    end else if (snd_sample) begin
      dc_x <= psg_snd;
      dc_y <= dc_y_nxt;
    end
  end
`else
  // Fixed mid-scale centring: 0..1023 maps to -512..511.
  always_comb psg_c_nxt = $signed({1'b0, psg_snd} - 11'd512);
`endif

  // Stage 0 capture on the sample strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_vld <= 1'b0;
      fm_r   <= '0;
      psg_c  <= '0;
    end else begin
      s0_vld <= snd_sample;
      if (snd_sample) begin
        fm_r  <= fm_snd;
        psg_c <= psg_c_nxt;
      end
    end
  end

  // ---------------- S1: gain multiply, floor divide by 16 ----------------
  logic signed [24:0]    fm_m;
  logic signed [PMW-1:0] psg_m;
  logic signed [20:0]    fm_p;
  logic signed [PPW-1:0] psg_p;
  logic                  s1_vld;

  // Gains are zero-extended to keep them positive in the signed product.
  always_comb begin
    fm_m  = 25'(fm_r) * 25'($signed({1'b0, fm_gain}));
    psg_m = PMW'($signed({psg_c, {PSG_SHIFT{1'b0}}})) * PMW'($signed({1'b0, psg_gain}));
  end

  // Stage 1 register; arithmetic shift gives floor toward -inf.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      fm_p   <= '0;
      psg_p  <= '0;
    end else begin
      s1_vld <= s0_vld;
      if (s0_vld) begin
        fm_p  <= 21'(fm_m >>> 4);
        psg_p <= PPW'(psg_m >>> 4);
      end
    end
  end

  // ---------------- S2: sum, saturate, clip flag ----------------
  logic signed [SW-1:0] sum;
  logic                 sat;

  // Sum and out-of-range detection for the sample leaving S1.
  always_comb begin
    sum = SW'(fm_p) + SW'(psg_p);
    sat = s1_vld && ((sum > SAT_HI) || (sum < SAT_LO));
  end

  // Output register; snd holds between valids, clip set has priority over clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      snd       <= '0;
      snd_valid <= 1'b0;
      clip      <= 1'b0;
    end else begin
      snd_valid <= s1_vld;
      if (s1_vld) begin
        if (sum > SAT_HI)      snd <= 16'sh7fff;
        else if (sum < SAT_LO) snd <= 16'sh8000;
        else                   snd <= sum[15:0];
      end
      if (sat)           clip <= 1'b1;
      else if (clip_clr) clip <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jt03_snd_mix.sv
// Bench for jt03_snd_mix (default build): directed steps with a scoreboard queue.
// Expected samples and their arrival cycle are queued at the strobe and checked on snd_valid.
// Clip and reset behaviour are checked inline at known cycles.
module tb_jt03_snd_mix;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] fm_snd;
  logic        [9:0]  psg_snd;
  logic               snd_sample;
  logic        [7:0]  fm_gain;
  logic        [7:0]  psg_gain;
  logic               clip_clr;
  logic signed [15:0] snd;
  logic               snd_valid;
  logic               clip;

  jt03_snd_mix dut (
    .clk        (clk),
    .rst        (rst),
    .fm_snd     (fm_snd),
    .psg_snd    (psg_snd),
    .snd_sample (snd_sample),
    .fm_gain    (fm_gain),
    .psg_gain   (psg_gain),
    .clip_clr   (clip_clr),
    .snd        (snd),
    .snd_valid  (snd_valid),
    .clip       (clip)
  );

  always #5 clk = ~clk;

  // cyc == number of rising edges seen so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    int due;
  } exp_t;
  exp_t q[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference mixer: centre, shift by 5, Q4.4 gains with floor, saturate.
  function automatic int model(input int fm, input int psg, input int fg, input int pg);
    int fp, pp, s;
    fp = (fm * fg) >>> 4;
    pp = (((psg - 512) * 32) * pg) >>> 4;
    s  = fp + pp;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic check(input string tag, input int got, input int want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  // Output monitor: every valid must match the head of the scoreboard at its due cycle.
  always @(negedge clk) begin
    if (snd_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("snd", int'(snd), e.val);
        check("latency_cycle", cyc, e.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_gains(input int fg, input int pg);
    fm_gain  = 8'(fg);
    psg_gain = 8'(pg);
    tick();
  endtask

  // One-cycle strobe using the current gains.
  task automatic strobe(input int fm, input int psg);
    exp_t e;
    fm_snd     = 16'(fm);
    psg_snd    = 10'(psg);
    snd_sample = 1'b1;
    e.val = model(fm, psg, int'(fm_gain), int'(psg_gain));
    e.due = cyc + 3;
    q.push_back(e);
    tick();
    snd_sample = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 20) begin
      tick();
      t++;
    end
    if (q.size() != 0) begin
      check("drain_timeout", q.size(), 0);
      q.delete();
    end
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    fm_snd     = '0;
    psg_snd    = '0;
    snd_sample = 1'b0;
    fm_gain    = 8'h10;
    psg_gain   = 8'h10;
    clip_clr   = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reset state
    check("reset_snd", int'(snd), 0);
    check("reset_valid", int'(snd_valid), 0);
    check("reset_clip", int'(clip), 0);

    // unity mix, PSG at mid-scale
    set_gains(8'h10, 8'h10);
    strobe(1000, 512);
    drain();

    // PSG path extremes and mute
    strobe(0, 1023);
    drain();
    strobe(0, 0);
    drain();
    set_gains(8'h10, 8'h00);
    strobe(0, 0);
    drain();
    check("no_clip_yet", int'(clip), 0);

    // gain extremes: 0xFF with negative FM, 0 on full-negative FM
    set_gains(8'hFF, 8'h00);
    strobe(-1000, 1023);
    drain();
    set_gains(8'h00, 8'h10);
    strobe(-32768, 300);
    drain();

    // positive saturation sets clip
    set_gains(8'h20, 8'h20);
    strobe(30000, 1023);
    drain();
    check("clip_after_pos_sat", int'(clip), 1);
    // negative saturation, clip stays set
    strobe(-32768, 512);
    drain();
    check("clip_sticky", int'(clip), 1);
    // clear without saturation
    clip_clr = 1'b1;
    tick();
    clip_clr = 1'b0;
    check("clip_cleared", int'(clip), 0);
    // saturation on the same edge as clip_clr: set wins
    strobe(30000, 1023);
    tick();
    clip_clr = 1'b1;
    tick();
    clip_clr = 1'b0;
    check("clip_set_beats_clr", int'(clip), 1);
    drain();
    clip_clr = 1'b1;
    tick();
    clip_clr = 1'b0;
    check("clip_cleared_again", int'(clip), 0);

    // throughput: 8 back-to-back strobes
    set_gains(8'h10, 8'h10);
    for (int i = 1; i <= 8; i++) strobe(i, 512);
    drain();
    tick();
    check("hold_snd", int'(snd), 8);
    check("hold_valid", int'(snd_valid), 0);

    // mixed non-unity gains, back-to-back pseudo-random samples
    set_gains(8'h18, 8'h0C);
    for (int i = 0; i < 6; i++) strobe(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 1023)));
    drain();

    // reset mid-stream with strobes active
    set_gains(8'h20, 8'h20);
    strobe(30000, 1023);
    drain();
    set_gains(8'h10, 8'h10);
    for (int i = 0; i < 6; i++) strobe(100 + i, 512);
    rst        = 1'b1;
    snd_sample = 1'b1;
    fm_snd     = 16'd777;
    psg_snd    = 10'd512;
    @(negedge clk);
    #1;
    q.delete();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_valid_low", int'(snd_valid), 0);
    end
    rst        = 1'b0;
    snd_sample = 1'b0;
    check("rst_snd", int'(snd), 0);
    check("rst_clip", int'(clip), 0);
    repeat (4) tick();
    check("rst_no_stale_valid", int'(snd_valid), 0);
    strobe(55, 512);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
